// File: rtl/jpeg_pkg.sv
// Shared JPEG decode-path constants and coefficient type.
package jpeg_pkg;
  localparam int COEFF_W   = 8;
  localparam int BLOCK_LEN = 64;
  localparam int POS_W     = $clog2(BLOCK_LEN);

  typedef logic signed [COEFF_W-1:0] coeff_t;
endpackage

// File: rtl/dpcm_dc_recon.sv
// DC reference holder: keeps the frame reference DC and adds it to incoming DC differences.
module dpcm_dc_recon #(
  parameter int DATA_W   = 8,
  parameter int REF_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic signed [DATA_W-1:0] dc_in,
  input  logic                     dc_strobe,
  input  logic                     frame_clr,
  output logic signed [DATA_W-1:0] dc_out
);
  logic signed [DATA_W-1:0] r_ref_dc;
  logic                     r_ref_latched;

  // First DC of a frame passes through; later ones are diffs added mod 2^DATA_W.
  always_comb begin
    dc_out = dc_in;
    if (r_ref_latched) dc_out = dc_in + r_ref_dc;
  end

  // Reference update: latch first DC, optionally track the previous block's DC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_dc      <= '0;
      r_ref_latched <= 1'b0;
    end else if (ce) begin
      if (frame_clr) begin
        r_ref_dc      <= '0;
        r_ref_latched <= 1'b0;
      end else if (dc_strobe) begin
        if (!r_ref_latched) begin
          r_ref_dc      <= dc_in;
          r_ref_latched <= 1'b1;
        end else if (REF_MODE != 0) begin
          r_ref_dc <= dc_out;
        end
      end
    end
  end
endmodule

// File: rtl/dpcm_dc_decoder.sv
// DC DPCM decoder: rebuilds absolute DC values per 8x8 block, passes AC through, 1-cycle latency.
module dpcm_dc_decoder
  import jpeg_pkg::*;
#(
  parameter int DATA_W    = COEFF_W,
  parameter int BLOCK_LEN = jpeg_pkg::BLOCK_LEN,
  parameter int REF_MODE  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     v_sync,
  input  logic signed [DATA_W-1:0] coeff_in,
  input  logic                     in_valid,
  output logic signed [DATA_W-1:0] coeff_out,
  output logic                     out_valid,
  output logic                     out_dc,
  output logic                     out_last,
  output logic [15:0]              block_cnt
);
  localparam int PW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [PW-1:0] LAST_POS = PW'(BLOCK_LEN - 1);

  logic [PW-1:0]            r_pos;
  logic signed [DATA_W-1:0] r_coeff;
  logic                     r_valid;
  logic                     r_dc;
  logic                     r_last;
  logic [15:0]              r_block_cnt;

  logic                     w_accept;
  logic                     w_is_dc;
  logic                     w_is_last;
  logic signed [DATA_W-1:0] w_dc_out;

  // A sample counts only on an enabled cycle that is not a frame restart; rst wins in the registers.
  always_comb begin
    w_accept  = ce & in_valid & ~v_sync;
    w_is_dc   = (r_pos == '0);
    w_is_last = (r_pos == LAST_POS);
  end

  dpcm_dc_recon #(
    .DATA_W   (DATA_W),
    .REF_MODE (REF_MODE)
  ) u_recon (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .dc_in     (coeff_in),
    .dc_strobe (w_accept & w_is_dc),
    .frame_clr (v_sync),
    .dc_out    (w_dc_out)
  );

  // Position counter, block counter and output stage with rst > v_sync > accept priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos       <= '0;
      r_coeff     <= '0;
      r_valid     <= 1'b0;
      r_dc        <= 1'b0;
      r_last      <= 1'b0;
      r_block_cnt <= '0;
    end else if (ce) begin
      if (v_sync) begin
        r_pos       <= '0;
        r_coeff     <= '0;
        r_valid     <= 1'b0;
        r_dc        <= 1'b0;
        r_last      <= 1'b0;
        r_block_cnt <= '0;
      end else if (w_accept) begin
        r_coeff <= w_is_dc ? w_dc_out : coeff_in;
        r_valid <= 1'b1;
        r_dc    <= w_is_dc;
        r_last  <= w_is_last;
        r_pos   <= w_is_last ? '0 : r_pos + 1'b1;
        if (w_is_last && r_block_cnt != 16'hFFFF) r_block_cnt <= r_block_cnt + 16'd1;
      end else begin
        r_valid <= 1'b0;
        r_dc    <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign coeff_out = r_coeff;
  assign out_valid = r_valid;
  assign out_dc    = r_dc;
  assign out_last  = r_last;
  assign block_cnt = r_block_cnt;
endmodule
